// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding
// and the default bit period for a 100 MHz clock at 115200 baud.
package uart_pkg;

    // Default clk cycles per UART bit (100 MHz / 115200).
    localparam int unsigned CLKS_PER_BIT_DEFAULT = 868;

    // Serial framing states, shared with a future transmitter.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_e;

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for a single asynchronous bit.
// Depth and reset value are parameters; depth must be at least 2.
module bit_sync #(
    parameter int   Depth    = 2,
    parameter logic ResetVal = 1'b1
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic q_o
);

    logic [Depth-1:0] sync_q;

    // Shift the async input through the flop chain.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync_q <= {Depth{ResetVal}};
        end else begin
            sync_q <= {sync_q[Depth-2:0], d_i};
        end
    end

    assign q_o = sync_q[Depth-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-entry valid/ready output buffer.
// Reports framing errors and dropped bytes as one-cycle pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned ClksPerBit = CLKS_PER_BIT_DEFAULT,
    parameter int unsigned SyncStages = 2
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       rx_i,
    output logic       valid_o,
    output logic [7:0] data_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o
);

    localparam int CntW = $clog2(ClksPerBit);
    localparam logic [CntW-1:0] HalfCnt = CntW'(ClksPerBit / 2 - 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(ClksPerBit - 1);

    logic            rx_s;
    uart_state_e     state_q;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;
    logic            frame_err_q;

    logic            full_q, full_d;
    logic [7:0]      data_q, data_d;
    logic            overrun_q, overrun_d;
    logic            byte_done;
    logic            xfer;

    bit_sync #(
        .Depth    (SyncStages),
        .ResetVal (1'b1)
    ) u_sync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .d_i     (rx_i),
        .q_o     (rx_s)
    );

    // A good stop bit completes the byte held in the shift register.
    assign byte_done = (state_q == ST_STOP) && (cnt_q == LastCnt) && rx_s;
    assign xfer      = full_q && ready_i;

    // Frame decoder: start validation, data sampling, stop check.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_q <= ST_START;
                        cnt_q   <= '0;
                    end
                end
                ST_START: begin
                    if (cnt_q == HalfCnt) begin
                        if (rx_s) begin
                            state_q <= ST_IDLE;
                        end else begin
                            state_q   <= ST_DATA;
                            cnt_q     <= '0;
                            bit_idx_q <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt_q == LastCnt) begin
                        shift_q[bit_idx_q] <= rx_s;
                        cnt_q              <= '0;
                        bit_idx_q          <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= ST_STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (cnt_q == LastCnt) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            state_q <= ST_IDLE;
                        end else begin
                            state_q     <= ST_BREAK;
                            frame_err_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_BREAK: begin
                    if (rx_s) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Output buffer next state: load, hold, drain or drop.
    always_comb begin
        full_d    = full_q;
        data_d    = data_q;
        overrun_d = 1'b0;
        if (byte_done) begin
            if (!full_q || ready_i) begin
                full_d = 1'b1;
                data_d = shift_q;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (xfer) begin
            full_d = 1'b0;
        end
    end

    // Output buffer registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            full_q    <= 1'b0;
            data_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            full_q    <= full_d;
            data_q    <= data_d;
            overrun_q <= overrun_d;
        end
    end

    assign valid_o     = full_q;
    assign data_o      = data_q;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit.
// A negedge monitor logs transfers and error pulses.
module tb_uart_rx;

    localparam int Cpb = 16;

    logic       clk;
    logic       reset_i;
    logic       rx_i;
    logic       valid_o;
    logic [7:0] data_o;
    logic       ready_i;
    logic       frame_err_o;
    logic       overrun_o;

    int n_checks;
    int n_fail;

    int         n_xfer;
    int         n_ferr;
    int         n_ovr;
    int         n_wide;
    logic [7:0] last_byte;
    logic       ferr_prev;
    logic       ovr_prev;

    uart_rx #(
        .ClksPerBit (Cpb),
        .SyncStages (2)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .rx_i        (rx_i),
        .valid_o     (valid_o),
        .data_o      (data_o),
        .ready_i     (ready_i),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log handshakes and pulses midway between rising edges.
    always @(negedge clk) begin
        if (reset_i) begin
            ferr_prev <= 1'b0;
            ovr_prev  <= 1'b0;
        end else begin
            if (valid_o && ready_i) begin
                n_xfer    <= n_xfer + 1;
                last_byte <= data_o;
            end
            if (frame_err_o) n_ferr <= n_ferr + 1;
            if (overrun_o) n_ovr <= n_ovr + 1;
            if ((frame_err_o && ferr_prev) || (overrun_o && ovr_prev))
                n_wide <= n_wide + 1;
            ferr_prev <= frame_err_o;
            ovr_prev  <= overrun_o;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic send_bit(input logic b);
        rx_i = b;
        ticks(Cpb);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    int xf0, fe0, ov0;

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        n_xfer    = 0;
        n_ferr    = 0;
        n_ovr     = 0;
        n_wide    = 0;
        last_byte = 8'h00;
        reset_i   = 1'b1;
        rx_i      = 1'b1;
        ready_i   = 1'b1;
        ticks(4);
        reset_i = 1'b0;
        ticks(4);

        check_eq("rst_valid", {31'd0, valid_o}, 32'd0);
        check_eq("rst_data", {24'd0, data_o}, 32'd0);
        check_eq("rst_ferr", {31'd0, frame_err_o}, 32'd0);
        check_eq("rst_ovr", {31'd0, overrun_o}, 32'd0);

        // Single byte, consumer always ready.
        send_frame(8'hA5, 1'b1);
        ticks(2 * Cpb);
        check_eq("a5_count", n_xfer, 32'd1);
        check_eq("a5_data", {24'd0, last_byte}, 32'h A5);
        check_eq("a5_ferr", n_ferr, 32'd0);
        check_eq("a5_ovr", n_ovr, 32'd0);
        check_eq("a5_valid", {31'd0, valid_o}, 32'd0);

        // Two bytes back to back with no consumer: second is dropped.
        ready_i = 1'b0;
        send_frame(8'hEC, 1'b1);
        send_frame(8'hAD, 1'b1);
        ticks(Cpb);
        check_eq("ovr_valid", {31'd0, valid_o}, 32'd1);
        check_eq("ovr_data", {24'd0, data_o}, 32'h EC);
        check_eq("ovr_count", n_ovr, 32'd1);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        tick();
        check_eq("ovr_drain", {31'd0, valid_o}, 32'd0);
        check_eq("ovr_byte", {24'd0, last_byte}, 32'h EC);
        check_eq("ovr_xfer", n_xfer, 32'd2);
        ready_i = 1'b1;

        // Bad stop bit followed by a long break, then a good byte.
        send_frame(8'h3C, 1'b0);
        ticks(20 * Cpb);
        rx_i = 1'b1;
        ticks(2 * Cpb);
        check_eq("brk_ferr", n_ferr, 32'd1);
        check_eq("brk_noxfer", n_xfer, 32'd2);
        send_frame(8'h5B, 1'b1);
        ticks(2 * Cpb);
        check_eq("brk_xfer", n_xfer, 32'd3);
        check_eq("brk_data", {24'd0, last_byte}, 32'h 5B);
        check_eq("brk_ferr2", n_ferr, 32'd1);

        // Short low glitch on an idle line is a false start.
        rx_i = 1'b0;
        ticks(4);
        rx_i = 1'b1;
        ticks(2 * Cpb);
        check_eq("gl_xfer", n_xfer, 32'd3);
        check_eq("gl_valid", {31'd0, valid_o}, 32'd0);
        check_eq("gl_ferr", n_ferr, 32'd1);
        check_eq("gl_ovr", n_ovr, 32'd1);

        // Reset in the middle of bit 4, then a clean frame.
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        rx_i = 1'b0;
        ticks(Cpb / 2);
        reset_i = 1'b1;
        rx_i    = 1'b1;
        ticks(2);
        check_eq("mid_valid", {31'd0, valid_o}, 32'd0);
        check_eq("mid_data", {24'd0, data_o}, 32'd0);
        check_eq("mid_ferr", {31'd0, frame_err_o}, 32'd0);
        check_eq("mid_ovr", {31'd0, overrun_o}, 32'd0);
        reset_i = 1'b0;
        ticks(2 * Cpb);
        xf0 = n_xfer;
        send_frame(8'h63, 1'b1);
        ticks(2 * Cpb);
        check_eq("mid_xfer", n_xfer, xf0 + 1);
        check_eq("mid_byte", {24'd0, last_byte}, 32'h 63);

        // Accept the first byte on the very cycle the second completes.
        ready_i = 1'b0;
        send_frame(8'h11, 1'b1);
        rx_i = 1'b1;
        ticks(Cpb);
        check_eq("same_v1", {31'd0, valid_o}, 32'd1);
        xf0 = n_xfer;
        fe0 = n_ferr;
        ov0 = n_ovr;
        fork
            send_frame(8'h22, 1'b1);
            begin
                ticks(9 * Cpb + 10);
                ready_i = 1'b1;
                check_eq("same_pre", {24'd0, data_o}, 32'h 11);
                tick();
                ready_i = 1'b0;
                check_eq("same_valid", {31'd0, valid_o}, 32'd1);
                check_eq("same_data", {24'd0, data_o}, 32'h 22);
            end
        join
        ticks(Cpb);
        check_eq("same_ovr", n_ovr, ov0);
        check_eq("same_ferr", n_ferr, fe0);
        check_eq("same_xfer", n_xfer, xf0 + 1);
        check_eq("same_byte", {24'd0, last_byte}, 32'h 11);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        tick();
        check_eq("same_drain", {31'd0, valid_o}, 32'd0);
        check_eq("same_last", {24'd0, last_byte}, 32'h 22);
        check_eq("pulse_width", n_wide, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
